// File: rtl/mem_line_responder_pkg.sv
// Shared memory-message widths, request type codes and responder state encodings.
`ifndef MEM_LINE_RESPONDER_PKG_SV
`define MEM_LINE_RESPONDER_PKG_SV

`define VC_MEM_MSG_TYPE_NBITS 3
`define VC_MEM_MSG_LEN_NBITS 4
`define VC_MEM_REQ_MSG_NBITS(o_, a_, d_) (`VC_MEM_MSG_TYPE_NBITS + (o_) + (a_) + `VC_MEM_MSG_LEN_NBITS + (d_))
`define VC_MEM_RESP_MSG_NBITS(o_, d_) (`VC_MEM_MSG_TYPE_NBITS + (o_) + `VC_MEM_MSG_LEN_NBITS + (d_))

package mem_line_responder_pkg;

  localparam logic [2:0] TYPE_READ       = 3'd0;
  localparam logic [2:0] TYPE_WRITE      = 3'd1;
  localparam logic [2:0] TYPE_WRITE_INIT = 3'd2;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_WAIT = 2'd1,
    STATE_RESP = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/mem_line_responder_array.sv
// Line store: synchronous per-byte write, combinational read of the same line index.
module mem_line_array #(
  parameter int p_nlines = 256,
  parameter int clw      = 128
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [$clog2(p_nlines)-1:0] idx,
  input  logic [clw/8-1:0]            wr_be,
  input  logic [clw-1:0]              wr_data,
  output logic [clw-1:0]              rd_data
);

  logic [clw-1:0] lines [p_nlines];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < clw/8; b++) begin
        if (wr_be[b]) lines[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = lines[idx];

endmodule

// File: rtl/mem_line_responder.sv
// Blocking cacheline memory responder with per-domain storage halves and fixed latency.
//   state      | meaning
//   STATE_IDLE | ready for a request; access performed on accept
//   STATE_WAIT | counting down the programmed extra latency
//   STATE_RESP | response valid, waiting for memresp_rdy
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int p_mem_nbytes   = 4096,
  parameter int p_opaque_nbits = 8,
  parameter int p_latency      = 2,
  parameter int abw            = 32,
  parameter int clw            = 128
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [`VC_MEM_REQ_MSG_NBITS(p_opaque_nbits,abw,clw)-1:0] memreq_msg,
  input  logic                                                 memreq_val,
  output logic                                                 memreq_rdy,
  output logic [`VC_MEM_RESP_MSG_NBITS(p_opaque_nbits,clw)-1:0]    memresp_msg,
  output logic                                                 memresp_val,
  input  logic                                                 memresp_rdy,
  input  logic                                                 sd
);

  localparam int NBYTES = clw / 8;
  localparam int NLINES = p_mem_nbytes / NBYTES;
  localparam int IDXW   = $clog2(NLINES);
  localparam int OFFW   = $clog2(NBYTES);
  localparam logic [3:0] LAT_LOAD = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

  logic [2:0]                req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [abw-1:0]            req_addr;
  logic [3:0]                req_len;
  logic [clw-1:0]            req_data;

  assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;

  logic [2:0]                resp_type;
  logic [p_opaque_nbits-1:0] resp_opaque;
  logic [3:0]                resp_len;
  logic [clw-1:0]            resp_data;

  assign memresp_msg = {resp_type, resp_opaque, resp_len, resp_data};

  state_t     state, state_next;
  logic [3:0] lat_cnt;
  logic       req_go;

  assign req_go = memreq_val & memreq_rdy;

  always_comb begin
    state_next  = state;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    case (state)
      STATE_IDLE: begin
        memreq_rdy = 1'b1;
        if (memreq_val) state_next = (p_latency > 0) ? STATE_WAIT : STATE_RESP;
      end
      STATE_WAIT: if (lat_cnt == 4'd0) state_next = STATE_RESP;
      STATE_RESP: begin
        memresp_val = 1'b1;
        if (memresp_rdy) state_next = STATE_IDLE;
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  // Domain bit on top keeps the two halves disjoint; upper address bits wrap.
  logic [IDXW-1:0]   line_idx;
  logic [OFFW-1:0]   offset;
  logic [NBYTES-1:0] wr_be;
  logic [clw-1:0]    wr_data;
  logic [clw-1:0]    rd_data;
  logic              is_write;
  logic              unused_addr_hi;

  assign line_idx       = {sd, req_addr[OFFW+IDXW-2:OFFW]};
  assign offset         = req_addr[OFFW-1:0];
  assign unused_addr_hi = ^req_addr[abw-1:OFFW+IDXW-1];
  assign is_write       = (req_type == TYPE_WRITE) || (req_type == TYPE_WRITE_INIT);

  // Bytes shifted past the line end simply fall off; there is no wrap.
  always_comb begin
    wr_be = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (req_len == 4'd0 ||
          (b >= int'(offset) && b < int'(offset) + int'(req_len)))
        wr_be[b] = 1'b1;
    end
  end

  assign wr_data = (req_len == 4'd0) ? req_data : (req_data << {offset, 3'b000});

  mem_line_array #(.p_nlines(NLINES), .clw(clw)) u_array (
    .clk     (clk),
    .wr_en   (req_go & is_write & ~reset),
    .idx     (line_idx),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= STATE_IDLE;
      lat_cnt     <= 4'd0;
      resp_type   <= '0;
      resp_opaque <= '0;
      resp_len    <= '0;
      resp_data   <= '0;
    end else begin
      state <= state_next;
      if (req_go) begin
        lat_cnt     <= LAT_LOAD;
        resp_type   <= req_type;
        resp_opaque <= req_opaque;
        resp_len    <= req_len;
        resp_data   <= (req_type == TYPE_READ) ? rd_data : '0;
      end else if (state == STATE_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: latency-2 instance plus a latency-0 instance.
module tb_mem_line_responder;

  localparam int REQ_W  = 3 + 8 + 32 + 4 + 128;
  localparam int RESP_W = 3 + 8 + 4 + 128;

  localparam logic [127:0] D1    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DA    = {32{4'hA}};
  localparam logic [127:0] D5    = {32{4'h5}};
  localparam logic [127:0] DPART = 128'h3344_0000_0000_0000_DEADBEEF_0000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [REQ_W-1:0]  req_msg, req_msg2;
  logic              req_val, req_val2;
  logic              req_rdy, req_rdy2;
  logic [RESP_W-1:0] resp_msg, resp_msg2;
  logic              resp_val, resp_val2;
  logic              resp_rdy, resp_rdy2;
  logic              sd, sd2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_line_responder #(.p_latency(2)) dut (
    .clk(clk), .reset(reset),
    .memreq_msg(req_msg), .memreq_val(req_val), .memreq_rdy(req_rdy),
    .memresp_msg(resp_msg), .memresp_val(resp_val), .memresp_rdy(resp_rdy),
    .sd(sd)
  );

  mem_line_responder #(.p_latency(0)) dut0 (
    .clk(clk), .reset(reset),
    .memreq_msg(req_msg2), .memreq_val(req_val2), .memreq_rdy(req_rdy2),
    .memresp_msg(resp_msg2), .memresp_val(resp_val2), .memresp_rdy(resp_rdy2),
    .sd(sd2)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                              input logic [31:0] a, input logic [3:0] l,
                                              input logic [127:0] d);
    return {t, op, a, l, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single cycle; caller ensures the DUT is idle.
  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [3:0] l, input logic [127:0] d, input logic s);
    req_msg = mk_req(t, op, a, l, d);
    sd      = s;
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
  endtask

  task automatic wait_resp(output logic [RESP_W-1:0] rsp, output int lat);
    lat = 1;
    while (!resp_val && lat < 40) begin
      tick();
      lat++;
    end
    if (!resp_val) check_eq("resp_timeout", resp_val, 1);
    rsp = resp_msg;
  endtask

  task automatic txn(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                     input logic [3:0] l, input logic [127:0] d, input logic s,
                     output logic [RESP_W-1:0] rsp, output int lat);
    send(t, op, a, l, d, s);
    wait_resp(rsp, lat);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RESP_W-1:0] rsp, held;
    int                lat, seen, first_cyc;
    int                resp_cyc[3];
    logic [7:0]        resp_op[3];
    logic [7:0]        op;
    logic              acc;

    reset = 1'b1; req_val = 1'b0; req_msg = '0; resp_rdy = 1'b1; sd = 1'b0;
    req_val2 = 1'b0; req_msg2 = '0; resp_rdy2 = 1'b1; sd2 = 1'b0;
    repeat (3) tick();
    check_eq("rst_req_rdy", req_rdy, 1);
    check_eq("rst_resp_val", resp_val, 0);
    check_eq("rst_resp_msg", resp_msg, 0);
    reset = 1'b0;
    tick();

    // Full-line write then read back
    txn(3'd1, 8'h05, 32'h40, 4'd0, D1, 1'b0, rsp, lat);
    check_eq("wr_latency", lat, 3);
    check_eq("wr_type", rsp[142:140], 3'd1);
    check_eq("wr_opaque", rsp[139:132], 8'h05);
    check_eq("wr_data_zero", rsp[127:0], 0);
    check_eq("after_rdy", req_rdy, 1);
    check_eq("after_val", resp_val, 0);
    txn(3'd0, 8'h06, 32'h40, 4'd3, '0, 1'b0, rsp, lat);
    check_eq("rd_type", rsp[142:140], 3'd0);
    check_eq("rd_opaque", rsp[139:132], 8'h06);
    check_eq("rd_len", rsp[131:128], 4'd3);
    check_eq("rd_data", rsp[127:0], D1);
    check_eq("rd_latency", lat, 3);
    txn(3'd0, 8'h07, 32'h840, 4'd0, '0, 1'b0, rsp, lat);
    check_eq("rd_wrap", rsp[127:0], D1);

    // Domain isolation
    txn(3'd1, 8'h10, 32'h80, 4'd0, DA, 1'b0, rsp, lat);
    txn(3'd2, 8'h11, 32'h80, 4'd0, D5, 1'b1, rsp, lat);
    check_eq("winit_type", rsp[142:140], 3'd2);
    txn(3'd0, 8'h12, 32'h80, 4'd0, '0, 1'b0, rsp, lat);
    check_eq("sd0_data", rsp[127:0], DA);
    txn(3'd0, 8'h13, 32'h80, 4'd0, '0, 1'b1, rsp, lat);
    check_eq("sd1_data", rsp[127:0], D5);

    // Partial writes, including one clipped at the line end
    txn(3'd1, 8'h20, 32'h100, 4'd0, '0, 1'b0, rsp, lat);
    txn(3'd1, 8'h21, 32'h104, 4'd4, 128'hDEADBEEF, 1'b0, rsp, lat);
    txn(3'd1, 8'h22, 32'h10E, 4'd4, 128'h11223344, 1'b0, rsp, lat);
    txn(3'd0, 8'h23, 32'h100, 4'd0, '0, 1'b0, rsp, lat);
    check_eq("partial_data", rsp[127:0], DPART);

    // Unknown type: echoed, no storage change
    txn(3'd5, 8'h30, 32'h40, 4'd0, DA, 1'b0, rsp, lat);
    check_eq("other_type", rsp[142:140], 3'd5);
    check_eq("other_data", rsp[127:0], 0);
    txn(3'd0, 8'h31, 32'h40, 4'd0, '0, 1'b0, rsp, lat);
    check_eq("other_nochange", rsp[127:0], D1);

    // sd toggled while busy must not redirect the read
    send(3'd0, 8'h40, 32'h80, 4'd0, '0, 1'b0);
    sd = 1'b1;
    wait_resp(rsp, lat);
    tick();
    check_eq("sd_busy_data", rsp[127:0], DA);

    // Backpressure
    resp_rdy = 1'b0;
    send(3'd0, 8'h09, 32'h80, 4'd0, '0, 1'b1);
    wait_resp(held, lat);
    check_eq("bp_data", held[127:0], D5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_msg_stable", resp_msg, held);
      check_eq("bp_req_rdy", req_rdy, 0);
      check_eq("bp_val", resp_val, 1);
    end
    resp_rdy = 1'b1;
    tick();
    check_eq("bp_release_rdy", req_rdy, 1);
    check_eq("bp_release_val", resp_val, 0);

    // Reset during WAIT drops the read
    send(3'd0, 8'h77, 32'h40, 4'd0, '0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rstw_req_rdy", req_rdy, 1);
    check_eq("rstw_val", resp_val, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_val) seen++;
    end
    check_eq("rstw_no_resp", seen, 0);
    txn(3'd0, 8'h78, 32'h40, 4'd0, '0, 1'b0, rsp, lat);
    check_eq("rstw_committed", rsp[127:0], D1);

    // Zero-latency back-to-back
    op = 8'd1;
    seen = 0;
    req_msg2 = mk_req(3'd0, op, 32'h0, 4'd0, '0);
    req_val2 = 1'b1;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      acc = req_val2 & req_rdy2;
      if (resp_val2) begin
        resp_cyc[seen] = c;
        resp_op[seen]  = resp_msg2[139:132];
        seen++;
      end
      tick();
      if (acc) begin
        op++;
        if (op > 8'd3) req_val2 = 1'b0;
        else req_msg2 = mk_req(3'd0, op, 32'h0, 4'd0, '0);
      end
    end
    check_eq("b2b_count", seen, 3);
    first_cyc = resp_cyc[0];
    check_eq("b2b_first_cyc", first_cyc, 1);
    for (int i = 0; i < 3; i++) begin
      check_eq("b2b_opaque", resp_op[i], 8'(i + 1));
      check_eq("b2b_spacing", resp_cyc[i] - first_cyc, 2 * i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder that terminates the cacheline-width memreq/memresp val/rdy interface driven by a blocking cache's refill and evict path.
- Holds a line-organised storage array split into two equal halves, one per security domain. Input `sd` selects the half, so the two domains can never alias each other's lines.
- Blocking: one outstanding request, fixed programmable latency. Used as the backing store in cache unit tests and in the secure-processor memory system.

Parameters:
- p_mem_nbytes, 4096, total storage bytes; power of two, at least 2*clw/8.
- p_opaque_nbits, 8, opaque field width; echoed unchanged into the response.
- p_latency, 2, extra cycles between request accept and response valid; legal range 0..15.
- abw, 32, address width.
- clw, 128, cacheline / data width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- memreq_msg  in  `VC_MEM_REQ_MSG_NBITS(o,abw,clw)`  request, fields {type[2:0], opaque, addr, len[3:0], data[clw-1:0]}, MSB first.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memresp_msg  out  `VC_MEM_RESP_MSG_NBITS(o,clw)`  response, fields {type, opaque, len, data}.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.
- sd  in  1  security domain of the current transaction; selects the storage half.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. At reset: state=IDLE, memreq_rdy=1, memresp_val=0, memresp_msg=0, latency counter=0. Storage contents are not reset.
- Reset mid-operation: the in-flight request is dropped with no response. A write that was already committed to storage stays committed.

States:
- IDLE
  - memreq_rdy=1.
  - On memreq_val: latch type, opaque, addr, len, data and sd; perform the access this cycle; go to WAIT if p_latency>0, else RESP.
- WAIT
  - memreq_rdy=0. Counter loads p_latency-1 on accept and decrements each cycle.
  - At counter==0, go to RESP.
- RESP
  - memresp_val=1, memreq_rdy=0.
  - On memresp_rdy, return to IDLE; memresp_val drops the next cycle.
  - A new request is accepted no earlier than the cycle after the response handshake (no same-cycle turnaround).
  - memresp_msg is held stable while memresp_val=1 and memresp_rdy=0.

Latency and addressing:
- Latency from accept to memresp_val is p_latency+1 cycles.
- Line index = {sd, addr[log2(p_mem_nbytes)-2 : log2(clw/8)]}. High address bits are ignored (wrap-around within the domain half).
- Byte offset = addr[log2(clw/8)-1:0].

Request types:
- READ (3'd0)
  - resp.data = full stored line, regardless of offset or len.
  - resp.len = req.len.
- WRITE (3'd1) and WRITE_INIT (3'd2)
  - len==0 writes the full line with req.data; offset is ignored.
  - len=N≠0 writes bytes [offset, offset+N) from req.data bytes [0, N).
  - If offset+N exceeds clw/8, bytes past the line end are discarded; there is no wrap within the line.
  - resp.data = 0.
- Any other type: no storage change; the response type echoes the request type and resp.data = 0.
- Response type always equals request type; opaque is always echoed.

Domain and width rules:
- sd is sampled only at accept.
- Changes to sd while busy do not affect the in-flight transaction.
- The two halves are fully disjoint.

Decomposition:
- Shared package/header holds:
  - the message-type constants READ/WRITE/WRITE_INIT;
  - field-width and field-slice macros (existing `VC_MEM_*` macros);
  - state encodings STATE_IDLE, STATE_WAIT, STATE_RESP.
- One natural sub-module: mem_line_array. It is a synchronous-write, combinational-read line store with per-byte write enable, parameterised by line count and clw. The top contains the FSM, latency counter, request/response registers, byte-enable generation and domain index concatenation.

Test Plan:
- Write then read, p_latency=2, sd=0:
  - Write to addr 0x40, len=0, data 0x00112233_44556677_8899AABB_CCDDEEFF, opaque 0x05 → memresp_val rises 3 cycles after accept with type WRITE, opaque 0x05, data 0.
  - Read of 0x40 → returns that data, opaque echoed.
- Domain isolation:
  - Write 0xA…A to line 0x80 with sd=0 and 0x5…5 to line 0x80 with sd=1.
  - Reads return 0xA…A under sd=0 and 0x5…5 under sd=1.
- Partial write:
  - Full line 0 at 0x100, then write addr 0x104, len=4, data[31:0]=0xDEADBEEF.
  - Read 0x100 → bytes 4..7 = DEADBEEF, all other bytes 0.
  - Write addr 0x10E, len=4 → only bytes 14..15 change.
- Backpressure: hold memresp_rdy=0 for 5 cycles in RESP → memresp_msg stable, memreq_rdy=0 throughout; handshake on cycle 6, memreq_rdy=1 the next cycle.
- p_latency=0 back-to-back: continuous val/rdy → one response per 2 cycles; opaques 1, 2, 3 returned in order.
- Reset during WAIT: a read is in flight when reset is asserted for 1 cycle → no response appears, memreq_rdy=1 on the cycle after reset.
